// File: rtl/rv32i_forwarding_scoreboard_pkg.sv
// Shared types for the execute-stage forwarding/hazard unit: register address, operand source select.
package rv32i_forwarding_scoreboard_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int DEF_WORD_W = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DEF_WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FWD_NONE,
      FWD_STAGE,
      FWD_LATDONE,
      FWD_STALL
   } fwd_sel_t;

   function automatic logic sel_forwards(input fwd_sel_t s);
      return (s == FWD_STAGE) || (s == FWD_LATDONE);
   endfunction

endpackage

// File: rtl/rv32i_forwarding_scoreboard_if.sv
// Pipeline-side bundle of the forwarding unit; stall_cycles exists only with RV_FWD_STALL_CNT_EN.
interface rv32i_forwarding_scoreboard_if
   import rv32i_forwarding_scoreboard_pkg::*;
#(
   parameter int NUM_SRC        = 2,
   parameter int NUM_FWD_STAGES = 2,
   parameter int WORD_W         = 32
) ();

   logic [NUM_SRC-1:0][REG_ADDR_W-1:0]        rs_e;
   logic [NUM_FWD_STAGES-1:0][REG_ADDR_W-1:0] stg_rd;
   logic [NUM_FWD_STAGES-1:0]                 stg_wen;
   logic [NUM_FWD_STAGES-1:0]                 stg_data_vld;
   logic [NUM_FWD_STAGES-1:0][WORD_W-1:0]     stg_data;
   logic                                      lat_issue;
   logic [REG_ADDR_W-1:0]                     lat_rd;
   logic                                      lat_ready;
   logic                                      lat_done;
   logic [REG_ADDR_W-1:0]                     lat_done_rd;
   logic [WORD_W-1:0]                         lat_done_data;
   logic [NUM_SRC-1:0]                        fwd_en;
   logic [NUM_SRC-1:0][WORD_W-1:0]            fwd_data;
   logic                                      stall;
   logic [NUM_REGS-1:0]                       pending;
`ifdef RV_FWD_STALL_CNT_EN
   logic [31:0]                               stall_cycles;
`endif

   modport master (
      output rs_e, stg_rd, stg_wen, stg_data_vld, stg_data,
      output lat_issue, lat_rd, lat_done, lat_done_rd, lat_done_data,
      input  lat_ready, fwd_en, fwd_data, stall, pending
`ifdef RV_FWD_STALL_CNT_EN
      , input stall_cycles
`endif
   );

   modport slave (
      input  rs_e, stg_rd, stg_wen, stg_data_vld, stg_data,
      input  lat_issue, lat_rd, lat_done, lat_done_rd, lat_done_data,
      output lat_ready, fwd_en, fwd_data, stall, pending
`ifdef RV_FWD_STALL_CNT_EN
      , output stall_cycles
`endif
   );

endinterface

// File: rtl/rv32i_forwarding_scoreboard_fwd_src_select.sv
// Priority source selection for one execute operand: youngest stage, then completing long op, then scoreboard.
module fwd_src_select
   import rv32i_forwarding_scoreboard_pkg::*;
#(
   parameter int NUM_FWD_STAGES = 2,
   parameter int WORD_W         = 32,
   localparam int IDX_W         = (NUM_FWD_STAGES > 1) ? $clog2(NUM_FWD_STAGES) : 1
) (
   input  reg_addr_t                                 rs_i,
   input  logic [NUM_FWD_STAGES-1:0][REG_ADDR_W-1:0] stg_rd_i,
   input  logic [NUM_FWD_STAGES-1:0]                 stg_wen_i,
   input  logic [NUM_FWD_STAGES-1:0]                 stg_vld_i,
   input  logic [NUM_FWD_STAGES-1:0][WORD_W-1:0]     stg_data_i,
   input  logic                                      lat_done_i,
   input  reg_addr_t                                 lat_done_rd_i,
   input  logic [WORD_W-1:0]                         lat_done_data_i,
   input  logic                                      pend_hit_i,
   output fwd_sel_t                                  sel_o,
   output logic [IDX_W-1:0]                          stg_idx_o,
   output logic [WORD_W-1:0]                         data_o
);

   logic             hit;
   logic [IDX_W-1:0] idx;

   always_comb begin
      hit = 1'b0;
      idx = '0;
      // Walk oldest to youngest so the youngest match is the one left standing.
      for (int s = NUM_FWD_STAGES - 1; s >= 0; s--) begin
         if (stg_wen_i[s] && (stg_rd_i[s] == rs_i)) begin
            hit = 1'b1;
            idx = IDX_W'(s);
         end
      end
   end

   always_comb begin
      sel_o     = FWD_NONE;
      stg_idx_o = idx;
      data_o    = '0;
      if (rs_i != '0) begin
         if (hit) begin
            if (stg_vld_i[idx]) begin
               sel_o  = FWD_STAGE;
               data_o = stg_data_i[idx];
            end else begin
               sel_o = FWD_STALL;
            end
         end else if (lat_done_i && (lat_done_rd_i == rs_i)) begin
            sel_o  = FWD_LATDONE;
            data_o = lat_done_data_i;
         end else if (pend_hit_i) begin
            sel_o = FWD_STALL;
         end
      end
   end

endmodule

// File: rtl/rv32i_forwarding_scoreboard.sv
// Execute forwarding/hazard unit with a long-latency pending scoreboard.
// Optional stall cycle counter enabled by RV_FWD_STALL_CNT_EN.
module rv32i_forwarding_scoreboard
   import rv32i_forwarding_scoreboard_pkg::*;
#(
   parameter int NUM_SRC         = 2,
   parameter int NUM_FWD_STAGES  = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter int WORD_W          = 32
) (
   input  logic                         CLK,
   input  logic                         nRST,
   rv32i_forwarding_scoreboard_if.slave bus
);

   localparam int IDX_W = (NUM_FWD_STAGES > 1) ? $clog2(NUM_FWD_STAGES) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                lat_ready;
   logic                issue_ok;
   logic                done_ok;
   logic                stall;

   fwd_sel_t            sel      [NUM_SRC];
   logic [IDX_W-1:0]    stg_idx  [NUM_SRC];
   logic [WORD_W-1:0]   src_data [NUM_SRC];

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_select #(
         .NUM_FWD_STAGES (NUM_FWD_STAGES),
         .WORD_W         (WORD_W)
      ) u_sel (
         .rs_i            (bus.rs_e[i]),
         .stg_rd_i        (bus.stg_rd),
         .stg_wen_i       (bus.stg_wen),
         .stg_vld_i       (bus.stg_data_vld),
         .stg_data_i      (bus.stg_data),
         .lat_done_i      (bus.lat_done),
         .lat_done_rd_i   (bus.lat_done_rd),
         .lat_done_data_i (bus.lat_done_data),
         .pend_hit_i      (pending_q[bus.rs_e[i]]),
         .sel_o           (sel[i]),
         .stg_idx_o       (stg_idx[i]),
         .data_o          (src_data[i])
      );

      a_stage_data: assert property (@(posedge CLK) disable iff (!nRST)
         (sel[i] == FWD_STAGE) |-> (src_data[i] == bus.stg_data[stg_idx[i]]));
   end

   always_comb begin
      bus.fwd_en   = '0;
      bus.fwd_data = '0;
      stall        = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         bus.fwd_en[i]   = sel_forwards(sel[i]);
         bus.fwd_data[i] = src_data[i];
         stall           = stall | (sel[i] == FWD_STALL);
      end
   end

   // A completion in the same cycle frees the slot a full scoreboard needs.
   always_comb begin
      lat_ready = 1'b0;
      if (!pending_q[bus.lat_rd]) begin
         lat_ready = (count_q < MAX_CNT) || ((count_q == MAX_CNT) && bus.lat_done);
      end
   end

   assign issue_ok = bus.lat_issue && lat_ready;
   assign done_ok  = bus.lat_done && (count_q != '0);

   // Clear before set: issue and completion to the same rd leaves the bit set.
   always_comb begin
      pending_d = pending_q;
      if (done_ok && (bus.lat_done_rd != '0)) begin
         pending_d[bus.lat_done_rd] = 1'b0;
      end
      if (issue_ok && (bus.lat_rd != '0)) begin
         pending_d[bus.lat_rd] = 1'b1;
      end
   end

   always_comb begin
      count_d = count_q;
      case ({issue_ok, done_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pending_q <= '0;
         count_q   <= '0;
      end else begin
         pending_q <= pending_d;
         count_q   <= count_d;
      end
   end

   a_done_underflow: assert property (@(posedge CLK) disable iff (!nRST)
      !(bus.lat_done && (count_q == '0)));

   assign bus.lat_ready = lat_ready;
   assign bus.stall     = stall;
   assign bus.pending   = pending_q;

`ifdef RV_FWD_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.stall_cycles = stall_cnt_q;
`endif

endmodule
